// File: rtl/bomberman_pkg.sv
// Shared Bomberman constants: pixel coordinate width, tile size, bomb slot count.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: COORD_W, TILE_SHIFT, MAX_BOMBS, coord_t, tile_snap(), tile_idx().
package bomberman_pkg;

    localparam int COORD_W    = 10;
    localparam int TILE_SHIFT = 5;
    localparam int MAX_BOMBS  = 4;

    typedef logic [COORD_W-1:0] coord_t;

    // Snap a pixel coordinate down to the top-left pixel of its tile.
    function automatic coord_t tile_snap(input coord_t c);
        tile_snap = {c[COORD_W-1:TILE_SHIFT], {TILE_SHIFT{1'b0}}};
    endfunction

    // Tile index of a pixel coordinate (coordinate with the in-tile offset dropped).
    function automatic logic [COORD_W-TILE_SHIFT-1:0] tile_idx(input coord_t c);
        tile_idx = c[COORD_W-1:TILE_SHIFT];
    endfunction

endpackage

// File: rtl/bomb_scheduler_if.sv
// Bundle between the button/VGA side and the bomb scheduler.
// Latency: n/a (wires only).
// Backpressure: none; place_reject reports a refused placement in the request cycle.
// master: drives place_req, b_x/b_y, v_x/v_y. slave: drives the strobe, exploding
// coordinates, bomb_on, place_reject and active_count.
interface bomb_scheduler_if;
    import bomberman_pkg::*;

    logic       place_req;
    coord_t     b_x;
    coord_t     b_y;
    coord_t     v_x;
    coord_t     v_y;
    logic       explosion_write_enable;
    coord_t     exploding_bomb_x;
    coord_t     exploding_bomb_y;
    logic       bomb_on;
    logic       place_reject;
    logic [3:0] active_count;

    modport master (
        output place_req, b_x, b_y, v_x, v_y,
        input  explosion_write_enable, exploding_bomb_x, exploding_bomb_y,
        input  bomb_on, place_reject, active_count
    );

    modport slave (
        input  place_req, b_x, b_y, v_x, v_y,
        output explosion_write_enable, exploding_bomb_x, exploding_bomb_y,
        output bomb_on, place_reject, active_count
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after i_ptr (wrapping).
// Latency: combinational, 0 cycles.
// Backpressure: none; requesters not granted simply keep requesting.
// Ports: i_req[N-1:0] requests, i_ptr start index; o_gnt one-hot grant,
// o_idx granted index, o_vld any grant.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    int w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_j   = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!o_vld && i_req[w_j]) begin
                o_vld      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/bomb_scheduler.sv
// Multi-bomb controller: slot array with per-bomb fuses, one detonation strobe per cycle.
// Latency: strobe 1 cycle after a slot becomes pending; place_reject combinational in the request cycle.
// Backpressure: placements refused when full or duplicate tile; expiries queue and drain in RR order.
// Ports: sys_clk, Reset (async, active-high); bus (slave): place_req, b_x/b_y, v_x/v_y in;
// explosion_write_enable, exploding_bomb_x/y, bomb_on, place_reject, active_count out.
module bomb_scheduler #(
    parameter int MAX_BOMBS  = bomberman_pkg::MAX_BOMBS,
    parameter int FUSE_TICKS = 3,
    parameter int TICK_DIV   = 100_000_000
) (
    input  logic             sys_clk,
    input  logic             Reset,
    bomb_scheduler_if.slave  bus
);
    import bomberman_pkg::*;

    localparam int IW = $clog2(MAX_BOMBS);
    localparam int FW = $clog2(FUSE_TICKS + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Slot state
    logic [MAX_BOMBS-1:0] r_vld;
    coord_t               r_x    [MAX_BOMBS];
    coord_t               r_y    [MAX_BOMBS];
    logic [FW-1:0]        r_fuse [MAX_BOMBS];

    logic [PW-1:0]        r_presc;
    logic [IW-1:0]        r_ptr;
    logic                 r_ewe;
    coord_t               r_ex;
    coord_t               r_ey;
    logic [3:0]           r_cnt;

    logic                 w_tick;
    coord_t               w_tx;
    coord_t               w_ty;
    logic                 w_dup;
    logic                 w_free_vld;
    logic [IW-1:0]        w_free_idx;
    logic                 w_accept;
    logic [MAX_BOMBS-1:0] w_pend;
    logic [MAX_BOMBS-1:0] w_gnt;
    logic [IW-1:0]        w_gnt_idx;
    logic                 w_gnt_vld;
    logic [MAX_BOMBS-1:0] w_vld_nxt;
    logic [3:0]           w_cnt_nxt;
    logic                 w_bomb_on;

    // Fuse prescaler: tick is high during the cycle the counter sits at its top value.
    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_tx = tile_snap(bus.b_x);
    assign w_ty = tile_snap(bus.b_y);

    // Free-slot and duplicate checks see pre-edge valid bits, so a slot being granted
    // this cycle still counts as occupied.
    always_comb begin
        w_dup      = 1'b0;
        w_free_vld = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            if (r_vld[i] && (r_x[i] == w_tx) && (r_y[i] == w_ty)) begin
                w_dup = 1'b1;
            end
            if (!r_vld[i] && !w_free_vld) begin
                w_free_vld = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    assign w_accept = bus.place_req && w_free_vld && !w_dup;

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            w_pend[i] = r_vld[i] && (r_fuse[i] == '0);
        end
    end

    rr_arbiter #(.N(MAX_BOMBS)) u_arb (
        .i_req (w_pend),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_vld (w_gnt_vld)
    );

    // A granted slot is never the accepted slot (accepted slots are invalid pre-edge).
    always_comb begin
        w_vld_nxt = r_vld & ~w_gnt;
        if (w_accept) begin
            w_vld_nxt[w_free_idx] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            w_cnt_nxt = w_cnt_nxt + 4'(w_vld_nxt[i]);
        end
    end

    // A newly placed bomb loads the full fuse even on a tick cycle.
    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            r_vld <= '0;
            for (int i = 0; i < MAX_BOMBS; i++) begin
                r_x[i]    <= '0;
                r_y[i]    <= '0;
                r_fuse[i] <= '0;
            end
        end else begin
            r_vld <= w_vld_nxt;
            for (int i = 0; i < MAX_BOMBS; i++) begin
                if (w_accept && (w_free_idx == IW'(i))) begin
                    r_x[i]    <= w_tx;
                    r_y[i]    <= w_ty;
                    r_fuse[i] <= FW'(FUSE_TICKS);
                end else if (w_tick && r_vld[i] && (r_fuse[i] != '0)) begin
                    r_fuse[i] <= r_fuse[i] - FW'(1);
                end
            end
        end
    end

    // Output registers; coordinates only change on a grant and are held otherwise.
    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            r_ptr <= '0;
            r_ewe <= 1'b0;
            r_ex  <= '0;
            r_ey  <= '0;
            r_cnt <= '0;
        end else begin
            r_ewe <= w_gnt_vld;
            r_cnt <= w_cnt_nxt;
            if (w_gnt_vld) begin
                r_ex  <= r_x[w_gnt_idx];
                r_ey  <= r_y[w_gnt_idx];
                r_ptr <= (w_gnt_idx == IW'(MAX_BOMBS - 1)) ? '0 : (w_gnt_idx + IW'(1));
            end
        end
    end

    always_comb begin
        w_bomb_on = 1'b0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            if (r_vld[i] && (tile_idx(bus.v_x) == tile_idx(r_x[i])) &&
                (tile_idx(bus.v_y) == tile_idx(r_y[i]))) begin
                w_bomb_on = 1'b1;
            end
        end
    end

    assign bus.explosion_write_enable = r_ewe;
    assign bus.exploding_bomb_x       = r_ex;
    assign bus.exploding_bomb_y       = r_ey;
    assign bus.active_count           = r_cnt;
    assign bus.place_reject           = bus.place_req && !w_accept;
    assign bus.bomb_on                = w_bomb_on;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Self-checking bench for bomb_scheduler with a tile-level bomb model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bomb_scheduler;
    import bomberman_pkg::*;

    localparam int TD   = 4;
    localparam int FT   = 3;
    localparam int NB   = 4;
    localparam int TILE = 1 << TILE_SHIFT;

    logic sys_clk = 1'b0;
    logic Reset   = 1'b1;

    always #5 sys_clk = ~sys_clk;

    bomb_scheduler_if bif();

    bomb_scheduler #(
        .MAX_BOMBS  (NB),
        .FUSE_TICKS (FT),
        .TICK_DIV   (TD)
    ) dut (
        .sys_clk (sys_clk),
        .Reset   (Reset),
        .bus     (bif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each bomb is a tile index pair plus the number of ticks still to wait.
    bit m_live [NB];
    int m_tx   [NB];
    int m_ty   [NB];
    int m_left [NB];
    int m_cyc, m_rr, m_ex, m_ey, m_cnt;
    bit m_ewe;

    logic       obs_ewe, obs_rej;
    logic [3:0] obs_cnt;
    coord_t     obs_ex, obs_ey;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NB; i++) begin
            m_live[i] = 1'b0; m_tx[i] = 0; m_ty[i] = 0; m_left[i] = 0;
        end
        m_cyc = 0; m_rr = 0; m_ex = 0; m_ey = 0; m_cnt = 0; m_ewe = 1'b0;
    endtask

    function automatic bit m_reject(input bit pr, input int bx, input int by);
        bit dup, full;
        dup  = 1'b0;
        full = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (m_live[i] && m_tx[i] == bx / TILE && m_ty[i] == by / TILE) dup = 1'b1;
            if (!m_live[i]) full = 1'b0;
        end
        return pr && (dup || full);
    endfunction

    function automatic bit m_bomb_on(input int vx, input int vy);
        for (int i = 0; i < NB; i++) begin
            if (m_live[i] && m_tx[i] == vx / TILE && m_ty[i] == vy / TILE) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_step(input bit pr, input int bx, input int by);
        bit acc;
        int freei, g, j;
        acc   = pr && !m_reject(pr, bx, by);
        freei = -1;
        for (int i = 0; i < NB; i++) if (!m_live[i] && freei < 0) freei = i;
        // oldest-expired-first is not the rule: the next expired bomb after the last one fired
        g = -1;
        for (int k = 0; k < NB; k++) begin
            j = (m_rr + k) % NB;
            if (g < 0 && m_live[j] && m_left[j] == 0) g = j;
        end
        m_ewe = (g >= 0);
        if (g >= 0) begin
            m_ex = m_tx[g] * TILE;
            m_ey = m_ty[g] * TILE;
            m_live[g] = 1'b0;
            m_rr = (g + 1) % NB;
        end
        if (m_cyc % TD == TD - 1) begin
            for (int i = 0; i < NB; i++) if (m_live[i] && m_left[i] > 0) m_left[i]--;
        end
        if (acc) begin
            m_live[freei] = 1'b1;
            m_tx[freei]   = bx / TILE;
            m_ty[freei]   = by / TILE;
            m_left[freei] = FT;
        end
        m_cyc++;
        m_cnt = 0;
        for (int i = 0; i < NB; i++) m_cnt += int'(m_live[i]);
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic step(input bit pr, input int bx, input int by, input int vx, input int vy);
        bif.place_req = pr;
        bif.b_x = COORD_W'(bx);
        bif.b_y = COORD_W'(by);
        bif.v_x = COORD_W'(vx);
        bif.v_y = COORD_W'(vy);
        #1;
        obs_ewe = bif.explosion_write_enable;
        obs_rej = bif.place_reject;
        obs_cnt = bif.active_count;
        obs_ex  = bif.exploding_bomb_x;
        obs_ey  = bif.exploding_bomb_y;
        chk("strobe", obs_ewe, m_ewe);
        if (m_ewe) begin
            chk("bomb_x", obs_ex, m_ex);
            chk("bomb_y", obs_ey, m_ey);
        end
        chk("active_count", obs_cnt, m_cnt);
        chk("place_reject", obs_rej, m_reject(pr, bx, by));
        chk("bomb_on", bif.bomb_on, m_bomb_on(vx, vy));
        m_step(pr, bx, by);
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (m_cnt != 0 || obs_cnt != 0); i++) idle(1);
        chk("drain_empty", obs_cnt, 0);
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, got, s, hits, st;
        coord_t cx, cy;
        bif.place_req = 1'b0;
        bif.b_x = '0; bif.b_y = '0; bif.v_x = '0; bif.v_y = '0;
        m_reset();
        repeat (3) @(negedge sys_clk);
        chk("rst_strobe", bif.explosion_write_enable, 0);
        chk("rst_x", bif.exploding_bomb_x, 0);
        chk("rst_y", bif.exploding_bomb_y, 0);
        chk("rst_count", bif.active_count, 0);
        chk("rst_reject", bif.place_reject, 0);
        chk("rst_bomb_on", bif.bomb_on, 0);
        Reset = 1'b0;

        // 1: single bomb, latency and coordinates
        step(1'b1, 70, 40, 64, 32);
        chk("t1_accept", obs_rej, 0);
        step(1'b0, 0, 0, 70, 40);
        chk("t1_count_one", obs_cnt, 1);
        lat = -1; cx = '0; cy = '0;
        for (int i = 2; i < 40 && lat < 0; i++) begin
            step(1'b0, 0, 0, 500, 500);
            if (obs_ewe === 1'b1) begin
                lat = i; cx = obs_ex; cy = obs_ey;
            end
        end
        chk("t1_latency", lat, 13);
        chk("t1_x", cx, 64);
        chk("t1_y", cy, 32);
        chk("t1_count_zero", obs_cnt, 0);
        step(1'b0, 0, 0, 0, 0);
        chk("t1_strobe_one_cycle", obs_ewe, 0);

        // 2: duplicate tile rejected
        step(1'b1, 200, 100, 0, 0);
        step(1'b1, 210, 110, 0, 0);
        chk("t2_dup_reject", obs_rej, 1);
        step(1'b0, 0, 0, 0, 0);
        chk("t2_count", obs_cnt, 1);
        drain();

        // 3/4/5: fill in one tick window, reject when full, retry across the freeing grant
        for (int i = 0; i < TD && (m_cyc % TD) != TD - 1; i++) idle(1);
        step(1'b1, 5, 5, 0, 0);
        step(1'b1, 70, 5, 0, 0);
        step(1'b1, 135, 5, 0, 0);
        step(1'b1, 200, 5, 0, 0);
        step(1'b1, 300, 300, 0, 0);
        chk("t3_full_reject", obs_rej, 1);
        chk("t3_count_full", obs_cnt, 4);
        got = -1;
        for (int i = 0; i < 40 && got < 0; i++) begin
            step(1'b1, 400, 400, 0, 0);
            if (obs_rej === 1'b0) got = i;
        end
        chk("t5_rejected_first", (got > 0), 1);
        chk("t5_accept_with_strobe", obs_ewe, 1);
        s = int'(obs_ewe);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 0, 0, 0);
            s += int'(obs_ewe);
        end
        chk("t4_consecutive_strobes", s, 4);
        drain();

        // 6: reset mid-fuse
        step(1'b1, 40, 40, 0, 0);
        step(1'b1, 100, 40, 0, 0);
        step(1'b1, 40, 100, 0, 0);
        idle(5);
        chk("t6_count_live", obs_cnt, 3);
        #2 Reset = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("t6_strobe", bif.explosion_write_enable, 0);
        chk("t6_count", bif.active_count, 0);
        chk("t6_x", bif.exploding_bomb_x, 0);
        chk("t6_y", bif.exploding_bomb_y, 0);
        hits = 0;
        for (int vx = 0; vx < 1024; vx += 16) begin
            for (int vy = 0; vy < 1024; vy += 16) begin
                bif.v_x = COORD_W'(vx);
                bif.v_y = COORD_W'(vy);
                #1;
                if (bif.bomb_on !== 1'b0) hits++;
            end
        end
        chk("t6_bomb_on_sweep", hits, 0);
        @(negedge sys_clk);
        Reset = 1'b0;
        m_reset();
        obs_cnt = '0;
        st = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            st += int'(obs_ewe);
        end
        chk("t6_no_strobe", st, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 127), $urandom_range(0, 95),
                 $urandom_range(0, 159), $urandom_range(0, 127));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
